// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: DREQ arbitration, HRQ/HLDA hold handshake and DACK issue
// for the DMA engine; owns the channel mask and terminal-count status registers.
`default_nettype none

module dma_channel_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] dreq_i,
  input  logic              mask_wr_i,
  input  logic [NUM_CH-1:0] mask_in_i,
  input  logic              rotate_en_i,
  input  logic [NUM_CH-1:0] demand_mode_i,
  input  logic              hlda_i,
  input  logic              xfer_done_i,
  input  logic              eop_i,
  input  logic              status_rd_i,
  output logic              hrq_o,
  output logic [NUM_CH-1:0] dack_o,
  output logic              aen_o,
  output logic              xfer_start_o,
  output logic [CW-1:0]     grant_ch_o,
  output logic [NUM_CH-1:0] mask_out_o,
  output logic [NUM_CH-1:0] tc_status_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_GRANT   = 3'd2,
    S_XFER    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     grant_q;
  logic [CW-1:0]     ptr_q;
  logic              hrq_q;
  logic [NUM_CH-1:0] dack_q;
  logic              aen_q;
  logic              xs_q;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] tc_q, tc_d;

  logic [NUM_CH-1:0] req_w;
  logic [CW-1:0]     base_w;
  logic [CW:0]       idx_w;
  logic              win_valid;
  logic [CW-1:0]     win_ch;
  logic [NUM_CH-1:0] grant_oh;
  logic              cur_req;
  logic [CW-1:0]     ptr_next;
  logic              eop_set;

  // Search starts at the rotation pointer (or ch0 in fixed mode) and wraps.
  always_comb begin
    req_w     = dreq_i & ~mask_q;
    base_w    = rotate_en_i ? ptr_q : '0;
    idx_w     = '0;
    win_valid = 1'b0;
    win_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_w = {1'b0, base_w} + (CW+1)'(i);
      if (idx_w >= (CW+1)'(NUM_CH)) idx_w = idx_w - (CW+1)'(NUM_CH);
      if (!win_valid && req_w[idx_w[CW-1:0]]) begin
        win_valid = 1'b1;
        win_ch    = idx_w[CW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
    cur_req           = dreq_i[grant_q] & ~mask_q[grant_q];
    ptr_next          = (grant_q == CW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    eop_set           = (state_q == S_XFER) && hlda_i && xfer_done_i && eop_i;
  end

  // EOP updates are applied after the host load/clear so the EOP bit wins.
  always_comb begin
    mask_d = mask_wr_i ? mask_in_i : mask_q;
    tc_d   = status_rd_i ? '0 : tc_q;
    if (eop_set) begin
      mask_d[grant_q] = 1'b1;
      tc_d[grant_q]   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      aen_q   <= 1'b0;
      xs_q    <= 1'b0;
      mask_q  <= '1;
      tc_q    <= '0;
    end else begin
      mask_q <= mask_d;
      tc_q   <= tc_d;
      xs_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid) begin
            grant_q <= win_ch;
            hrq_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (hlda_i) begin
            if (cur_req) begin
              state_q <= S_GRANT;
              xs_q    <= 1'b1;
              dack_q  <= grant_oh;
              aen_q   <= 1'b1;
            end else begin
              state_q <= S_RELEASE;
              hrq_q   <= 1'b0;
            end
          end
        end
        S_GRANT: begin
          if (!hlda_i) begin
            state_q <= S_IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= '0;
            aen_q   <= 1'b0;
          end else begin
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (!hlda_i) begin
            state_q <= S_IDLE;
            hrq_q   <= 1'b0;
            dack_q  <= '0;
            aen_q   <= 1'b0;
          end else if (xfer_done_i) begin
            if (!eop_i && demand_mode_i[grant_q] && cur_req) begin
              state_q <= S_GRANT;
              xs_q    <= 1'b1;
            end else begin
              state_q <= S_RELEASE;
              hrq_q   <= 1'b0;
              dack_q  <= '0;
              aen_q   <= 1'b0;
              ptr_q   <= ptr_next;
            end
          end
        end
        S_RELEASE: begin
          if (!hlda_i) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          hrq_q   <= 1'b0;
          dack_q  <= '0;
          aen_q   <= 1'b0;
        end
      endcase
    end
  end

  assign hrq_o        = hrq_q;
  assign dack_o       = dack_q;
  assign aen_o        = aen_q;
  assign xfer_start_o = xs_q;
  assign grant_ch_o   = grant_q;
  assign mask_out_o   = mask_q;
  assign tc_status_o  = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed sequence with a grant scoreboard checked on
// every xfer_start pulse.
`default_nettype none

module tb_dma_channel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] dreq, mask_in, demand_mode;
  logic       mask_wr, rotate_en, hlda, xfer_done, eop, status_rd;
  logic       hrq_o, aen_o, xfer_start_o;
  logic [3:0] dack_o, mask_out_o, tc_status_o;
  logic [1:0] grant_ch_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_push = 0;
  int          n_xs = 0;
  bit          host_auto = 1'b0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  dma_channel_arbiter #(.NUM_CH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dreq_i(dreq), .mask_wr_i(mask_wr),
    .mask_in_i(mask_in), .rotate_en_i(rotate_en), .demand_mode_i(demand_mode),
    .hlda_i(hlda), .xfer_done_i(xfer_done), .eop_i(eop), .status_rd_i(status_rd),
    .hrq_o(hrq_o), .dack_o(dack_o), .aen_o(aen_o), .xfer_start_o(xfer_start_o),
    .grant_ch_o(grant_ch_o), .mask_out_o(mask_out_o), .tc_status_o(tc_status_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Host echoes hrq as hlda shortly after each edge when enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (host_auto) hlda = hrq_o;
  endtask

  task automatic push_exp(input int unsigned ch);
    exp_q.push_back(ch);
    n_push++;
  endtask

  task automatic wait_xfer();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (aen_o === 1'b1 && xfer_start_o === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $error("FAIL xfer_timeout: observed no XFER state expected XFER within 20 cycles");
    end
  endtask

  task automatic pulse_done(input logic e);
    xfer_done = 1'b1;
    eop       = e;
    tick();
    xfer_done = 1'b0;
    eop       = 1'b0;
  endtask

  // Scoreboard: every xfer_start must match the next expected channel.
  always @(negedge clk) begin
    if (xfer_start_o === 1'b1) begin
      logic [3:0]  one;
      int unsigned e;
      one = 4'b0001;
      n_xs++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_unexpected: observed xfer_start on ch %0d expected none", grant_ch_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant", 32'(grant_ch_o), e);
        check("sb_dack", 32'(dack_o), 32'(one << e));
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; dreq = '0; mask_in = '0; demand_mode = '0;
    mask_wr = 1'b0; rotate_en = 1'b0; hlda = 1'b0;
    xfer_done = 1'b0; eop = 1'b0; status_rd = 1'b0;
    tick(); tick();
    check("rst_hrq", 32'(hrq_o), 0);
    check("rst_dack", 32'(dack_o), 0);
    check("rst_aen", 32'(aen_o), 0);
    check("rst_xs", 32'(xfer_start_o), 0);
    check("rst_grant", 32'(grant_ch_o), 0);
    check("rst_tc", 32'(tc_status_o), 0);
    check("rst_mask", 32'(mask_out_o), 32'hF);

    // All channels masked: requests are ignored.
    rst_n = 1'b1; host_auto = 1'b1; dreq = 4'b1111;
    tick(); tick(); tick();
    check("masked_hrq", 32'(hrq_o), 0);
    mask_wr = 1'b1; mask_in = 4'b0000;
    tick();
    mask_wr = 1'b0;
    check("mask_load", 32'(mask_out_o), 0);
    push_exp(0);
    tick();
    check("unmask_hrq", 32'(hrq_o), 1);
    check("unmask_grant", 32'(grant_ch_o), 0);
    wait_xfer();
    dreq = 4'b0000;
    pulse_done(1'b0);
    tick();

    // Fixed priority: ch1 then ch3.
    dreq = 4'b1010;
    push_exp(1); push_exp(3);
    tick();
    check("fix_grant1", 32'(grant_ch_o), 1);
    wait_xfer();
    check("fix_dack1", 32'(dack_o), 32'b0010);
    dreq = 4'b1000;
    pulse_done(1'b0);
    check("rel_dack", 32'(dack_o), 0);
    check("rel_aen", 32'(aen_o), 0);
    check("rel_hrq", 32'(hrq_o), 0);
    tick();
    tick();
    check("fix_grant3", 32'(grant_ch_o), 3);
    wait_xfer();
    dreq = 4'b0000;
    pulse_done(1'b0);
    tick();

    // Rotating priority with all requests held.
    rotate_en = 1'b1; dreq = 4'b1111;
    for (int i = 0; i < 5; i++) push_exp(i % 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rot_grant%0d", i), 32'(grant_ch_o), i % 4);
      wait_xfer();
      pulse_done(1'b0);
      tick();
    end
    dreq = 4'b0000;

    // Demand mode on ch2: three transfers, last with EOP.
    rotate_en = 1'b0; demand_mode = 4'b0100; dreq = 4'b0100;
    push_exp(2); push_exp(2); push_exp(2);
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_xfer();
      pulse_done(k == 2);
      if (k < 2) check($sformatf("dem_hrq%0d", k), 32'(hrq_o), 1);
    end
    check("dem_end_hrq", 32'(hrq_o), 0);
    check("dem_tc", 32'(tc_status_o), 32'b0100);
    check("dem_mask", 32'(mask_out_o), 32'b0100);
    dreq = 4'b0000;
    tick();
    check("tc_sticky", 32'(tc_status_o), 32'b0100);
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
    check("tc_clear", 32'(tc_status_o), 0);

    // Host abort during XFER; pointer (now 3) must not move.
    mask_wr = 1'b1; mask_in = 4'b0000; demand_mode = 4'b0000;
    tick();
    mask_wr = 1'b0; rotate_en = 1'b1; dreq = 4'b0010;
    push_exp(1);
    tick();
    check("abt_grant", 32'(grant_ch_o), 1);
    wait_xfer();
    host_auto = 1'b0; hlda = 1'b0;
    tick();
    check("abt_dack", 32'(dack_o), 0);
    check("abt_aen", 32'(aen_o), 0);
    check("abt_hrq", 32'(hrq_o), 0);
    check("abt_tc", 32'(tc_status_o), 0);
    dreq = 4'b1111; host_auto = 1'b1;
    push_exp(3);
    tick();
    check("abt_ptr_grant", 32'(grant_ch_o), 3);
    wait_xfer();
    dreq = 4'b0000;
    pulse_done(1'b0);
    tick();

    // Asynchronous reset mid-XFER, away from the clock edge.
    rotate_en = 1'b0; dreq = 4'b0001;
    push_exp(0);
    tick();
    wait_xfer();
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_hrq", 32'(hrq_o), 0);
    check("areset_dack", 32'(dack_o), 0);
    check("areset_aen", 32'(aen_o), 0);
    check("areset_mask", 32'(mask_out_o), 32'hF);
    check("areset_grant", 32'(grant_ch_o), 0);
    tick();
    rst_n = 1'b1;
    mask_wr = 1'b1; mask_in = 4'b0000;
    tick();
    mask_wr = 1'b0;
    check("post_rst_hrq", 32'(hrq_o), 0);
    push_exp(0);
    tick();
    check("post_rst_req", 32'(hrq_o), 1);
    check("post_rst_grant", 32'(grant_ch_o), 0);
    wait_xfer();
    dreq = 4'b0000;
    pulse_done(1'b0);
    tick();
    tick();

    check("sb_count", 32'(n_xs), 32'(n_push));
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dma_channel_arbiter.md
# dma_channel_arbiter

Bus-ownership and channel-service sequencer for the 4-channel DMA engine. Arbitrates DREQ lines, runs the HRQ/HLDA hold handshake with the host, and issues DACK. Hands one transfer at a time to the timing/control and datapath blocks via a start/done handshake. Owns the mask and terminal-count (TC) status registers.

## Interface
- NUM_CH, 4, number of DMA channels (grant_ch width is clog2(NUM_CH))
- CLK  input  1  system clock, all state on rising edge
- RESET  input  1  asynchronous, active-low reset
- dreq  input  NUM_CH  channel requests, active-high, level
- mask_wr  input  1  load mask register from mask_in
- mask_in  input  NUM_CH  new mask value (1 = channel masked)
- rotate_en  input  1  1 = rotating priority, 0 = fixed (ch0 highest)
- demand_mode  input  NUM_CH  per-channel: 1 = demand, 0 = single transfer
- hlda  input  1  host hold acknowledge
- xfer_done  input  1  one-cycle pulse: current transfer complete
- eop  input  1  terminal count reached; valid with xfer_done
- status_rd  input  1  one-cycle pulse: host read TC status (clear-on-read)
- hrq  output  1  hold request to host
- dack  output  NUM_CH  one-hot channel acknowledge
- aen  output  1  DMA owns address bus
- xfer_start  output  1  one-cycle pulse: begin transfer for grant_ch
- grant_ch  output  clog2(NUM_CH)  channel being serviced
- mask_out  output  NUM_CH  current mask register
- tc_status  output  NUM_CH  sticky TC flags

## Operation
- FSM states: IDLE, REQ, GRANT, XFER, RELEASE.
- IDLE: when any dreq & ~mask_out is set, latch the winner into grant_ch. Go to REQ.
- REQ: hrq=1. On hlda=1:
  - latched channel's dreq still high and unmasked: go to GRANT.
  - otherwise: go to RELEASE with no dack and no priority update.
- GRANT (exactly 1 cycle): xfer_start=1, dack[grant_ch]=1, aen=1. Go to XFER.
- XFER: hold dack and aen. On xfer_done:
  - eop=1: set tc_status[grant_ch] and mask_out[grant_ch]. Go to RELEASE.
  - eop=0, demand_mode[grant_ch]=1, dreq[grant_ch] still high: go to GRANT (next transfer, bus retained).
  - otherwise: go to RELEASE.
- RELEASE: hrq=0, dack=0, aen=0. Wait for hlda=0, then go to IDLE.
- Priority:
  - Fixed: lowest index wins.
  - Rotating: a 2-bit pointer names the highest-priority channel. On entering RELEASE from XFER, the pointer becomes grant_ch+1 mod NUM_CH. The pointer resets to 0.
- hlda dropping in GRANT or XFER is a host abort: go to IDLE immediately. dack, aen and hrq go to 0. No tc/mask update, no rotation.
- Mask register:
  - mask_wr loads mask_in.
  - An EOP mask-set in the same cycle ORs over the loaded value (EOP bit wins).
  - Masking grant_ch while in XFER does not abort the current transfer. It only blocks continuation in demand mode.
- tc_status:
  - status_rd clears all bits at the next edge.
  - A bit set by EOP in the same cycle as status_rd survives.
- Reset (asynchronous, any state): state=IDLE, hrq=0, dack=0, aen=0, xfer_start=0, grant_ch=0, tc_status=0, mask_out=all ones, pointer=0.

## Timing
- Outputs are decoded from the registered state and registers only; no combinational path from inputs to outputs.
- hrq rises 1 cycle after the edge that samples a qualifying dreq.
- dack, aen and xfer_start appear 1 cycle after the edge that samples hlda=1.
- xfer_start is high for exactly one cycle per transfer.
- Demand back-to-back: the next xfer_start comes 1 cycle after xfer_done is sampled (XFER→GRANT).
- dack/aen fall 1 cycle after the final xfer_done sample. hrq falls in the same cycle.
- Minimum single-transfer occupancy, assuming hlda responds within one cycle and xfer_done in the first XFER cycle: IDLE→REQ→GRANT→XFER→RELEASE→IDLE = 5 edges.

## Test plan
- Reset release, all masks set, dreq=4'b1111 -> hrq stays 0. Write mask_in=0 -> hrq=1 next cycle; grant_ch=0 in fixed mode.
- Fixed priority, dreq=4'b1010, single mode, hlda echoes hrq -> ch1 serviced first (dack=4'b0010, one xfer_start), bus released, then ch3 serviced.
- Rotating priority, dreq=4'b1111 held, four single transfers -> grant order 0,1,2,3, then 0 again.
- Demand mode on ch2 with dreq held for 3 xfer_done pulses, third with eop=1 -> three xfer_start pulses, hrq never drops between them. Then tc_status=4'b0100 and mask_out[2]=1. status_rd clears tc_status next cycle.
- hlda dropped during XFER -> dack=0, aen=0, hrq=0 next cycle; tc_status unchanged; priority pointer unchanged.
- Async RESET asserted mid-XFER, away from a clock edge -> all outputs reach reset values immediately. mask_out=4'b1111 and the FSM is in IDLE after deassertion.
